// File: rtl/fifo_arb_pkg.sv
// Shared state type and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;

  // Index width that stays at least one bit wide, even for a range of one value.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request strictly after `last_i`, wrapping modulo NUM_REQ.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   pick_o,
  output logic               any_req_o
);

  always_comb begin
    logic found;
    int   idx;
    pick_o = '0;
    found  = 1'b0;
    idx    = 0;
    // Offset starts at 1 so the previous owner is scanned last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (!found && req_i[IDX_W'(idx)]) begin
        pick_o = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of one synchronous-FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = idx_w(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_t      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   pick;
  logic            any_req;
  logic            owner_req;
  logic [DATA_WIDTH-1:0] owner_data;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_pick (
    .req_i     (req),
    .last_i    (last_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_req    = req[owner_q];
  assign fifo_w_en    = !rst && (state_q == ARB_BURST) && owner_req && !fifo_full;
  assign fifo_data_in = fifo_w_en ? owner_data : '0;
  assign busy         = (state_q == ARB_BURST);
  assign owner        = owner_q;

  always_comb begin
    gnt          = '0;
    gnt[owner_q] = fifo_w_en;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // A full FIFO only stalls; the burst ends on owner drop or word budget.
        if (!owner_req) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end else if (!fifo_full) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ARB_IDLE;
            last_d  = owner_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomised scoreboard run.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic        busy;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_fail   = 0;

  // Producer models: each offers word(i, nxt[i]) until granted, up to lim[i] words.
  int       nxt[4];
  int       lim[4];
  int       base[4];
  logic [3:0] en;

  logic [7:0] exp_q[$];
  int         own_q[$];
  int         wc_q[$];

  typedef struct {
    int         id;
    logic [7:0] data;
  } sb_t;
  sb_t sb[$];
  int  pushed[4];

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy),
    .owner        (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] word(input int i, input int n);
    return 8'(base[i] + n);
  endfunction

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req[i] = en[i] && (nxt[i] < lim[i]);
      req_data[i*8 +: 8] = word(i, nxt[i]);
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 4; i++) if (gnt[i]) nxt[i]++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; en = '0;
    for (int i = 0; i < 4; i++) begin nxt[i] = 0; lim[i] = 0; base[i] = 0; pushed[i] = 0; end
    exp_q.delete(); own_q.delete(); wc_q.delete(); sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req_data = 32'h33221100; fifo_full = 1'b0;
    @(posedge clk); #1; #3;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++; if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", fifo_w_en); end
    @(posedge clk); #1;
    rst = 1'b0; #3;
    n_checks++; if (fifo_w_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: wen=%b busy=%b want 0 0", fifo_w_en, busy); end
    @(posedge clk); #1; #3;
    n_checks++; if (busy !== 1'b1 || owner !== 2'd0) begin n_fail++; $display("FAIL reset_first_owner: busy=%b owner=%0d want 1 0", busy, owner); end
    n_checks++; if (fifo_data_in !== 8'h00 || gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_word: gnt=%b data=%h want 0001 00", gnt, fifo_data_in); end
    rst = 1'b1; req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_lone_requester();
    int exp_c[6] = '{1, 2, 3, 4, 6, 7};
    logic [7:0] e;
    do_reset();
    en = 4'b0001; base[0] = 8'hA0; lim[0] = 6;
    for (int n = 0; n < 6; n++) exp_q.push_back(8'(8'hA0 + n));
    for (int c = 0; c < 12; c++) begin
      apply(); #3;
      if (fifo_w_en) begin
        wc_q.push_back(c);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL lone_gnt c=%0d: got %b want 0001", c, gnt); end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL lone_extra_write c=%0d: got %h want none", c, fifo_data_in); end
        else begin
          e = exp_q.pop_front();
          if (fifo_data_in !== e) begin n_fail++; $display("FAIL lone_data c=%0d: got %h want %h", c, fifo_data_in, e); end
        end
      end
      advance(); @(posedge clk); #1;
    end
    n_checks++; if (wc_q.size() != 6) begin n_fail++; $display("FAIL lone_write_count: got %0d want 6", wc_q.size()); end
    for (int k = 0; k < 6 && k < wc_q.size(); k++) begin
      n_checks++; if (wc_q[k] != exp_c[k]) begin n_fail++; $display("FAIL lone_write_cycle k=%0d: got %0d want %0d", k, wc_q[k], exp_c[k]); end
    end
  endtask

  task automatic test_all_requesting();
    logic [7:0] e;
    int eo;
    do_reset();
    en = 4'b1111;
    for (int i = 0; i < 4; i++) begin base[i] = i * 16; lim[i] = 8; end
    for (int b = 0; b < 5; b++)
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(8'((b % 4) * 16 + (b / 4) * 4 + j));
        own_q.push_back(b % 4);
      end
    for (int c = 0; c < 25; c++) begin
      apply(); #3;
      n_checks++; if (!$onehot0(gnt)) begin n_fail++; $display("FAIL all_onehot c=%0d: got %b", c, gnt); end
      if (fifo_w_en) begin
        wc_q.push_back(c);
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL all_extra_write c=%0d: got %h want none", c, fifo_data_in); end
        else begin
          e = exp_q.pop_front(); eo = own_q.pop_front();
          if (gnt !== 4'(1 << eo) || owner !== 2'(eo) || fifo_data_in !== e) begin
            n_fail++;
            $display("FAIL all_write c=%0d: gnt=%b owner=%0d data=%h want gnt=%b owner=%0d data=%h", c, gnt, owner, fifo_data_in, 4'(1 << eo), eo, e);
          end
        end
      end
      advance(); @(posedge clk); #1;
    end
    n_checks++; if (wc_q.size() != 20) begin n_fail++; $display("FAIL all_write_count: got %0d want 20", wc_q.size()); end
    for (int k = 0; k < 20 && k < wc_q.size(); k++) begin
      n_checks++;
      if (wc_q[k] != 5 * (k / 4) + 1 + (k % 4)) begin n_fail++; $display("FAIL all_write_cycle k=%0d: got %0d want %0d", k, wc_q[k], 5 * (k / 4) + 1 + (k % 4)); end
    end
  endtask

  task automatic test_full_stall();
    int exp_c[4] = '{1, 2, 6, 7};
    logic [7:0] e;
    do_reset();
    en = 4'b0100; base[2] = 8'h20; lim[2] = 6;
    for (int n = 0; n < 4; n++) exp_q.push_back(8'(8'h20 + n));
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      apply(); #3;
      if (c >= 3 && c <= 5) begin
        n_checks++;
        if (fifo_w_en !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1 || owner !== 2'd2) begin
          n_fail++; $display("FAIL full_stall c=%0d: wen=%b gnt=%b busy=%b owner=%0d want 0 0000 1 2", c, fifo_w_en, gnt, busy, owner);
        end
      end
      if (c == 8) begin
        n_checks++; if (busy !== 1'b0 || fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL full_burst_end: busy=%b wen=%b want 0 0", busy, fifo_w_en); end
      end
      if (fifo_w_en) begin
        wc_q.push_back(c);
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL full_extra_write c=%0d: got %h want none", c, fifo_data_in); end
        else begin
          e = exp_q.pop_front();
          if (fifo_data_in !== e || gnt !== 4'b0100) begin n_fail++; $display("FAIL full_write c=%0d: gnt=%b data=%h want 0100 %h", c, gnt, fifo_data_in, e); end
        end
      end
      advance(); @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    n_checks++; if (wc_q.size() != 4) begin n_fail++; $display("FAIL full_write_count: got %0d want 4", wc_q.size()); end
    for (int k = 0; k < 4 && k < wc_q.size(); k++) begin
      n_checks++; if (wc_q[k] != exp_c[k]) begin n_fail++; $display("FAIL full_write_cycle k=%0d: got %0d want %0d", k, wc_q[k], exp_c[k]); end
    end
  endtask

  task automatic test_early_drop();
    int exp_c[3] = '{1, 4, 5};
    logic [7:0] e;
    int eo;
    do_reset();
    en = 4'b1010; base[1] = 8'h10; lim[1] = 1; base[3] = 8'h30; lim[3] = 2;
    exp_q.push_back(8'h10); own_q.push_back(1);
    exp_q.push_back(8'h30); own_q.push_back(3);
    exp_q.push_back(8'h31); own_q.push_back(3);
    for (int c = 0; c < 7; c++) begin
      apply(); #3;
      if (c == 2) begin
        n_checks++; if (fifo_w_en !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL drop_no_write: wen=%b busy=%b want 0 1", fifo_w_en, busy); end
      end
      if (c == 3) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy=%b want 0", busy); end
      end
      if (fifo_w_en) begin
        wc_q.push_back(c);
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL drop_extra_write c=%0d: got %h want none", c, fifo_data_in); end
        else begin
          e = exp_q.pop_front(); eo = own_q.pop_front();
          if (gnt !== 4'(1 << eo) || fifo_data_in !== e) begin
            n_fail++; $display("FAIL drop_write c=%0d: gnt=%b data=%h want %b %h", c, gnt, fifo_data_in, 4'(1 << eo), e);
          end
        end
      end
      advance(); @(posedge clk); #1;
    end
    n_checks++; if (wc_q.size() != 3) begin n_fail++; $display("FAIL drop_write_count: got %0d want 3", wc_q.size()); end
    for (int k = 0; k < 3 && k < wc_q.size(); k++) begin
      n_checks++; if (wc_q[k] != exp_c[k]) begin n_fail++; $display("FAIL drop_write_cycle k=%0d: got %0d want %0d", k, wc_q[k], exp_c[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] e;
    do_reset();
    en = 4'b1000; base[3] = 8'h30; lim[3] = 6; base[1] = 8'h10; lim[1] = 4;
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin rst = 1'b1; en = 4'b1010; end
      if (c == 4) rst = 1'b0;
      apply(); #3;
      if (c == 3) begin
        n_checks++; if (fifo_w_en !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_mask: wen=%b gnt=%b want 0 0000", fifo_w_en, gnt); end
      end else if (c == 4) begin
        n_checks++; if (busy !== 1'b0 || owner !== 2'd0 || fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: busy=%b owner=%0d wen=%b want 0 0 0", busy, owner, fifo_w_en); end
      end else if (c == 5) begin
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd1 || gnt !== 4'b0010 || fifo_data_in !== 8'h10) begin
          n_fail++; $display("FAIL rstmid_next_owner: busy=%b owner=%0d gnt=%b data=%h want 1 1 0010 10", busy, owner, gnt, fifo_data_in);
        end
      end else if (fifo_w_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_extra_write c=%0d: got %h want none", c, fifo_data_in); end
        else begin
          e = exp_q.pop_front();
          if (fifo_data_in !== e || gnt !== 4'b1000) begin n_fail++; $display("FAIL rstmid_write c=%0d: gnt=%b data=%h want 1000 %h", c, gnt, fifo_data_in, e); end
        end
      end
      advance(); @(posedge clk); #1;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_missing_writes: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_random_scoreboard();
    int n_wr;
    int g;
    int k;
    sb_t ent;
    do_reset();
    n_wr = 0;
    for (int i = 0; i < 4; i++) begin base[i] = i * 64; lim[i] = 1 << 30; end
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 4; i++) en[i] = ($urandom_range(0, 3) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      apply();
      for (int i = 0; i < 4; i++) begin
        if (req[i] && pushed[i] == nxt[i]) begin
          ent.id = i; ent.data = word(i, nxt[i]);
          sb.push_back(ent);
          pushed[i]++;
        end
      end
      #3;
      n_checks++; if (fifo_full && |gnt) begin n_fail++; $display("FAIL rand_gnt_while_full c=%0d: gnt=%b want 0000", c, gnt); end
      n_checks++; if (!$onehot0(gnt) || (|gnt) !== fifo_w_en) begin n_fail++; $display("FAIL rand_gnt_shape c=%0d: gnt=%b wen=%b", c, gnt, fifo_w_en); end
      n_checks++; if ((gnt & ~req) != 4'b0000) begin n_fail++; $display("FAIL rand_gnt_without_req c=%0d: gnt=%b req=%b", c, gnt, req); end
      if (fifo_w_en) begin
        n_wr++;
        g = -1;
        for (int i = 0; i < 4; i++) if (gnt[i]) g = i;
        k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].id == g) k = j;
        n_checks++;
        if (k < 0) begin n_fail++; $display("FAIL rand_unexpected_write c=%0d: producer %0d data %h want no write", c, g, fifo_data_in); end
        else begin
          if (fifo_data_in !== sb[k].data) begin n_fail++; $display("FAIL rand_data c=%0d: producer %0d got %h want %h", c, g, fifo_data_in, sb[k].data); end
          sb.delete(k);
        end
      end
      advance(); @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    n_checks++; if (n_wr < 100) begin n_fail++; $display("FAIL rand_throughput: got %0d writes want >= 100", n_wr); end
    foreach (sb[j]) begin
      n_checks++;
      if (sb[j].data !== word(sb[j].id, nxt[sb[j].id])) begin
        n_fail++; $display("FAIL rand_pending producer %0d: got %h want %h", sb[j].id, sb[j].data, word(sb[j].id, nxt[sb[j].id]));
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; en = '0;
    test_reset();
    test_lone_requester();
    test_all_requesting();
    test_full_stall();
    test_early_drop();
    test_reset_mid_burst();
    test_random_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
